if_id_queue: RTL and testbench

- Instruction-fetch queue sitting directly downstream of the PC register and instruction memory, upstream of decode.
- Captures {PC, instruction} pairs from fetch and buffers up to DEPTH entries, so a decode stall does not force the PC to freeze in the same cycle.
- Presents the oldest entry to decode with a valid/ready handshake and supports a branch/jump flush.

---
 rtl/if_id_queue.sv | 97 +++++++++
 tb/tb_if_id_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: buffers {PC, instruction} pairs between fetch and decode.
// Optional IF_ID_QUEUE_STATS_EN adds bubble_cnt/stall_cnt performance counters.
module if_id_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [31:0]              fetch_pc,
    input  logic [31:0]              fetch_instr,
    output logic                     fetch_ready,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_pc_plus4,
    output logic [31:0]              id_instr,
    output logic                     id_misalign,
    input  logic                     id_ready,
`ifdef IF_ID_QUEUE_STATS_EN
    output logic [31:0]              bubble_cnt,
    output logic [31:0]              stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic          r_mis   [DEPTH];
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;

    // fetch_ready depends only on registered occupancy, so a full queue never pushes on a pop cycle
    assign fetch_ready = (r_count < CW'(DEPTH));
    assign id_valid    = (r_count != '0);
    assign w_push      = fetch_valid && fetch_ready;
    assign w_pop       = id_valid && id_ready;
    assign count       = r_count;

    assign id_pc       = id_valid ? r_pc[r_rptr]    : 32'h0;
    assign id_instr    = id_valid ? r_instr[r_rptr] : NOP_INSTR;
    assign id_misalign = id_valid ? r_mis[r_rptr]   : 1'b0;
    assign id_pc_plus4 = id_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (w_push && !reset && !flush) begin
            r_pc[r_wptr]    <= fetch_pc;
            r_instr[r_wptr] <= fetch_instr;
            r_mis[r_wptr]   <= (fetch_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IF_ID_QUEUE_STATS_EN
    // Counters survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= 32'h0;
            stall_cnt  <= 32'h0;
        end else begin
            if (!id_valid) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (fetch_valid && !fetch_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed plan steps plus random traffic
// compared against a queue-based reference model.
module tb_if_id_queue;

    localparam int          DEPTH     = 2;
    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   fetch_valid;
    logic [31:0]            fetch_pc;
    logic [31:0]            fetch_instr;
    logic                   fetch_ready;
    logic                   id_valid;
    logic [31:0]            id_pc;
    logic [31:0]            id_pc_plus4;
    logic [31:0]            id_instr;
    logic                   id_misalign;
    logic                   id_ready;
    logic [$clog2(DEPTH):0] count;
`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0]            bubble_cnt;
    logic [31:0]            stall_cnt;
`endif

    entry_t      mdlQ[$];
    logic [31:0] mdlBubble;
    logic [31:0] mdlStall;
    int          testsRun;
    int          failCount;

    if_id_queue #(
        .DEPTH(DEPTH),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr),
        .fetch_ready(fetch_ready),
        .id_valid(id_valid),
        .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4),
        .id_instr(id_instr),
        .id_misalign(id_misalign),
        .id_ready(id_ready),
`ifdef IF_ID_QUEUE_STATS_EN
        .bubble_cnt(bubble_cnt),
        .stall_cnt(stall_cnt),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against what the reference queue says it should be
    task automatic checkAll(input string tag);
        logic [31:0] ePc;
        logic [31:0] eInstr;
        logic        eMis;
        if (mdlQ.size() == 0) begin
            ePc    = 32'h0;
            eInstr = NOP_INSTR;
            eMis   = 1'b0;
        end else begin
            ePc    = mdlQ[0].pc;
            eInstr = mdlQ[0].instr;
            eMis   = (ePc % 4) != 0;
        end
        checkOutput({tag, ".count"},       32'(count),          32'(mdlQ.size()));
        checkOutput({tag, ".id_valid"},    32'(id_valid),       32'(mdlQ.size() != 0));
        checkOutput({tag, ".fetch_ready"}, 32'(fetch_ready),    32'(mdlQ.size() < DEPTH));
        checkOutput({tag, ".id_pc"},       id_pc,               ePc);
        checkOutput({tag, ".id_pc_plus4"}, id_pc_plus4,         ePc + 32'd4);
        checkOutput({tag, ".id_instr"},    id_instr,            eInstr);
        checkOutput({tag, ".id_misalign"}, 32'(id_misalign),    32'(eMis));
`ifdef IF_ID_QUEUE_STATS_EN
        checkOutput({tag, ".bubble_cnt"},  bubble_cnt,          mdlBubble);
        checkOutput({tag, ".stall_cnt"},   stall_cnt,           mdlStall);
`endif
    endtask

    // Drive one cycle of inputs, advance the reference model, clock, then check
    task automatic applyStimulus(input string tag, input logic rst, input logic fl,
                                 input logic fv, input logic [31:0] pc,
                                 input logic [31:0] ins, input logic idr);
        int sz;
        sz          = mdlQ.size();
        reset       = rst;
        flush       = fl;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = ins;
        id_ready    = idr;
        if (rst) begin
            mdlQ.delete();
            mdlBubble = 32'h0;
            mdlStall  = 32'h0;
        end else begin
            if (sz == 0) mdlBubble = mdlBubble + 32'd1;
            if (fv && sz >= DEPTH) mdlStall = mdlStall + 32'd1;
            if (fl) begin
                mdlQ.delete();
            end else begin
                if (sz != 0 && idr) void'(mdlQ.pop_front());
                if (fv && sz < DEPTH) mdlQ.push_back('{pc, ins});
            end
        end
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        testsRun    = 0;
        failCount   = 0;
        mdlBubble   = 32'h0;
        mdlStall    = 32'h0;
        reset       = 1'b1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc    = 32'h0;
        fetch_instr = 32'h0;
        id_ready    = 1'b0;

        // Reset then idle
        applyStimulus("rst0", 1, 0, 0, 32'h0, 32'h0, 0);
        applyStimulus("rst1", 1, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("rst.id_instr",    id_instr,    32'h00000000);
        checkOutput("rst.id_pc_plus4", id_pc_plus4, 32'h00000004);
        for (int i = 0; i < 5; i++) applyStimulus("idle", 0, 0, 0, 32'h0, 32'h0, 0);
`ifdef IF_ID_QUEUE_STATS_EN
        checkOutput("idle.bubble5", bubble_cnt, 32'd5);
`endif

        // Single pass-through
        applyStimulus("pass.push", 0, 0, 1, 32'h00400000, 32'h8C220004, 1);
        checkOutput("pass.pc",    id_pc,       32'h00400000);
        checkOutput("pass.plus4", id_pc_plus4, 32'h00400004);
        applyStimulus("pass.pop", 0, 0, 0, 32'h0, 32'h0, 1);
        checkOutput("pass.drained", 32'(id_valid), 32'd0);

        // Fill and backpressure
        applyStimulus("fill.0", 0, 0, 1, 32'h0, 32'h11111111, 0);
        applyStimulus("fill.4", 0, 0, 1, 32'h4, 32'h22222222, 0);
        checkOutput("fill.full", 32'(fetch_ready), 32'd0);
        applyStimulus("fill.8rej", 0, 0, 1, 32'h8, 32'h33333333, 0);
        applyStimulus("fill.pop0", 0, 0, 1, 32'h8, 32'h33333333, 1);
        checkOutput("fill.head4", id_pc, 32'h4);
        applyStimulus("fill.pop4", 0, 0, 1, 32'h8, 32'h33333333, 1);
        checkOutput("fill.head8", id_pc, 32'h8);
        applyStimulus("fill.pop8", 0, 0, 0, 32'h0, 32'h0, 1);

        // Simultaneous push/pop at count 1
        applyStimulus("sim.c", 0, 0, 1, 32'h0C, 32'h44444444, 0);
        applyStimulus("sim.pp", 0, 0, 1, 32'h10, 32'h55555555, 1);
        checkOutput("sim.head10", id_pc, 32'h10);

        // Flush priority over push and pop
        applyStimulus("fl.fill", 0, 0, 1, 32'h14, 32'h66666666, 0);
        applyStimulus("fl.go", 0, 1, 1, 32'h20, 32'h77777777, 1);
        checkOutput("fl.count", 32'(count), 32'd0);
        applyStimulus("fl.after", 0, 0, 0, 32'h0, 32'h0, 1);

        // Boundaries: PC wrap and misaligned PC
        applyStimulus("bnd.wrap", 0, 0, 1, 32'hFFFFFFFC, 32'h88888888, 0);
        checkOutput("bnd.plus4", id_pc_plus4, 32'h00000000);
        applyStimulus("bnd.mis", 0, 0, 1, 32'h00000006, 32'h99999999, 1);
        checkOutput("bnd.misalign", 32'(id_misalign), 32'd1);
        applyStimulus("bnd.drain", 0, 0, 0, 32'h0, 32'h0, 1);

        // Randomized traffic with occasional flush and mid-stream reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            applyStimulus("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) != 0), rpc, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
